// File: rtl/inst_fetch_arb_pkg.sv
// Shared constants and types for the instruction-fetch / debug ROM arbiter.
// Optional feature macro: DBG_PORT_EN. When it is defined, the S_DBG state is
// included. When it is undefined, the FSM has only S_IDLE and S_IF.
package inst_fetch_arb_pkg;
  localparam int INST_ADDR_W  = 32;  // InstAddrBus
  localparam int INST_W       = 32;  // InstBus
  localparam int STARVE_CNT_W = 4;   // StarveCntBus

  typedef logic [INST_ADDR_W-1:0]  inst_addr_t;
  typedef logic [INST_W-1:0]       inst_t;
  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

  localparam inst_t ZERO_WORD    = '0;
  localparam logic  RST_ENABLE   = 1'b1;
  localparam logic  CHIP_ENABLE  = 1'b1;
  localparam logic  CHIP_DISABLE = 1'b0;

  // The state names the owner of last cycle's grant.
`ifdef DBG_PORT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_IF = 2'd1, S_DBG = 2'd2} arb_state_e;
`else
  typedef enum logic {S_IDLE = 1'b0, S_IF = 1'b1} arb_state_e;
`endif
endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter for the debug requester.
// The count rises each cycle that a debug request is pending but not granted.
// It saturates at STARVE_MAX. It clears on reset, on request withdrawal, or on a grant.
// Ports: clk, rst (sync, active-high), dbg_req, dbg_gnt -> at_max (count == STARVE_MAX).
module arb_starve_cnt
  import inst_fetch_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic at_max
);
  localparam starve_cnt_t CNT_MAX = starve_cnt_t'(STARVE_MAX);

  starve_cnt_t cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || !dbg_req || dbg_gnt) cnt <= '0;
    else if (cnt != CNT_MAX)                      cnt <= cnt + 1'b1;
  end

  assign at_max = (cnt == CNT_MAX);
endmodule

// File: rtl/inst_fetch_arb.sv
// Arbiter for the fetch stage and the debug/loader port, which share one
// combinational instruction ROM.
// Each cycle, at most one requester gets the ROM. The grant is combinational.
// The read data is captured at the grant edge and returned one cycle later,
// together with if_valid or dbg_ack.
// Fetch normally wins. A pending debug request is forced through after it has
// lost STARVE_MAX consecutive cycles.
// Optional feature macro: DBG_PORT_EN. When it is undefined, the debug inputs
// are ignored, dbg_ack and dbg_inst are tied to 0, and if_stallreq is 0.
// Ports: clk, rst (sync, active-high);
//   fetch: if_req, if_addr -> if_inst, if_valid, if_stallreq;
//   debug: dbg_req, dbg_addr -> dbg_inst, dbg_ack;
//   ROM:   rom_ce, rom_addr -> rom_inst.
module inst_fetch_arb
  import inst_fetch_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  inst_addr_t if_addr,
  output inst_t      if_inst,
  output logic       if_valid,
  output logic       if_stallreq,
  input  logic       dbg_req,
  input  inst_addr_t dbg_addr,
  output inst_t      dbg_inst,
  output logic       dbg_ack,
  output logic       rom_ce,
  output inst_addr_t rom_addr,
  input  inst_t      rom_inst
);
  arb_state_e state, state_nxt;
  logic       if_gnt, dbg_gnt;
  logic       run;

  assign run = (rst != RST_ENABLE);

`ifdef DBG_PORT_EN
  logic starve_max;

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .dbg_req (dbg_req),
    .dbg_gnt (dbg_gnt),
    .at_max  (starve_max)
  );

  // Debug is never granted in its own ack cycle. Otherwise it takes the ROM
  // when fetch is idle, or when debug has been starved long enough.
  assign dbg_gnt     = run && dbg_req && (state != S_DBG) && (!if_req || starve_max);
  assign if_stallreq = run && if_req && !if_gnt;
  assign dbg_ack     = run && (state == S_DBG);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) dbg_inst <= ZERO_WORD;
    else if (dbg_gnt)      dbg_inst <= rom_inst;
  end
`else
  logic unused_dbg;
  assign unused_dbg  = ^{dbg_req, dbg_addr};
  assign dbg_gnt     = 1'b0;
  assign if_stallreq = 1'b0;
  assign dbg_ack     = 1'b0;
  assign dbg_inst    = ZERO_WORD;
`endif

  assign if_gnt = run && if_req && !dbg_gnt;

  always_comb begin
    state_nxt = S_IDLE;
    rom_ce    = CHIP_DISABLE;
    rom_addr  = ZERO_WORD;
    if (if_gnt) begin
      state_nxt = S_IF;
      rom_ce    = CHIP_ENABLE;
      rom_addr  = if_addr;
    end
`ifdef DBG_PORT_EN
    else if (dbg_gnt) begin
      state_nxt = S_DBG;
      rom_ce    = CHIP_ENABLE;
      rom_addr  = dbg_addr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state   <= S_IDLE;
      if_inst <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      if (if_gnt) if_inst <= rom_inst;
    end
  end

  // A read that is still in flight when reset rises is dropped. The response
  // flags are masked by rst in that same cycle.
  assign if_valid = run && (state == S_IF);
endmodule

// File: tb/tb_inst_fetch_arb.sv
module tb_inst_fetch_arb;
  import inst_fetch_arb_pkg::*;

  localparam int SMAX = 4;
`ifdef DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr, rom_inst, rom_addr, if_inst, dbg_inst;
  logic        if_valid, if_stallreq, dbg_ack, rom_ce;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_arb #(.STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .if_stallreq(if_stallreq),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_inst(dbg_inst), .dbg_ack(dbg_ack),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a[31:2]};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  // Reference model:
  //   who got the ROM last cycle;
  //   how many consecutive cycles debug has lost;
  //   the last word delivered to each requester.
  bit          m_last_if, m_last_dbg;
  int          m_lose;
  logic [31:0] m_if_inst, m_dbg_inst;
  bit          e_if_g, e_dbg_g;

  function automatic void grants();
    e_dbg_g = DBG_EN && !rst && dbg_req && !m_last_dbg && (!if_req || m_lose == SMAX);
    e_if_g  = !rst && if_req && !e_dbg_g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic eval();
    #1;
    grants();
    chk("rom_ce",   32'(rom_ce), 32'(e_if_g || e_dbg_g));
    chk("rom_addr", rom_addr, e_if_g ? if_addr : (e_dbg_g ? dbg_addr : 32'h0));
    chk("stall",    32'(if_stallreq), 32'(DBG_EN && !rst && if_req && !e_if_g));
    chk("if_valid", 32'(if_valid), 32'(m_last_if && !rst));
    chk("dbg_ack",  32'(dbg_ack), 32'(m_last_dbg && !rst));
    chk("if_inst",  if_inst, m_if_inst);
    chk("dbg_inst", dbg_inst, m_dbg_inst);
  endtask

  task automatic adv();
    @(posedge clk);
    grants();
    if (rst) begin
      m_last_if = 0; m_last_dbg = 0; m_lose = 0; m_if_inst = '0; m_dbg_inst = '0;
    end else begin
      if (e_if_g)  m_if_inst  = rom_word(if_addr);
      if (e_dbg_g) m_dbg_inst = rom_word(dbg_addr);
      m_last_if  = e_if_g;
      m_last_dbg = e_dbg_g;
      if (!dbg_req || e_dbg_g) m_lose = 0;
      else if (m_lose < SMAX)  m_lose++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; if_req = 0; dbg_req = 0; if_addr = '0; dbg_addr = '0;
    m_last_if = 0; m_last_dbg = 0; m_lose = 0; m_if_inst = '0; m_dbg_inst = '0;
    @(negedge clk);
    adv();
    eval();
    chk("lit_rst_ce", 32'(rom_ce), 32'h0);
    adv();
    rst = 0;
    eval();
    chk("lit_rst_if_inst",  if_inst, 32'h0);
    chk("lit_rst_dbg_inst", dbg_inst, 32'h0);
    chk("lit_rst_valid",    32'(if_valid), 32'h0);
    adv();

    // Fetch only: addresses 0, 4, 8 return ROM words 0, 1, 2.
    for (int i = 0; i < 4; i++) begin
      if_req  = (i < 3);
      if_addr = 32'(4 * i);
      eval();
      chk("lit_fetch_stall", 32'(if_stallreq), 32'h0);
      if (i > 0) begin
        chk("lit_fetch_valid", 32'(if_valid), 32'h1);
        chk("lit_fetch_inst",  if_inst, 32'hC0DE_0000 | 32'(i - 1));
      end
      adv();
    end

`ifdef DBG_PORT_EN
    // Debug only: the ack arrives one cycle after the grant, exactly once.
    if_req = 0; dbg_req = 1; dbg_addr = 32'h10;
    eval();
    chk("lit_dbg_addr", rom_addr, 32'h10);
    adv();
    dbg_req = 0;
    eval();
    chk("lit_dbg_ack",  32'(dbg_ack), 32'h1);
    chk("lit_dbg_inst", dbg_inst, 32'hC0DE_0004);
    adv();
    eval();
    chk("lit_dbg_once", 32'(dbg_ack), 32'h0);
    adv();

    // Contention: four fetch wins, then debug is forced, then fetch resumes.
    if_req = 1; dbg_req = 1; dbg_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      if_addr = 32'h100 + 32'(4 * k);
      if (k == 5) dbg_req = 0;
      eval();
      if (k < 4) begin
        chk("lit_cont_fetch", rom_addr, 32'h100 + 32'(4 * k));
        chk("lit_cont_stall0", 32'(if_stallreq), 32'h0);
      end else if (k == 4) begin
        chk("lit_cont_dbg", rom_addr, 32'h20);
        chk("lit_cont_stall1", 32'(if_stallreq), 32'h1);
      end else begin
        chk("lit_cont_ack", 32'(dbg_ack), 32'h1);
        chk("lit_cont_resume", rom_addr, 32'h114);
      end
      adv();
    end

    // Withdraw after two lost cycles: no ack, and the starvation count restarts.
    dbg_req = 1; dbg_addr = 32'h30;
    for (int k = 0; k < 2; k++) begin if_addr = 32'h200 + 32'(4 * k); eval(); adv(); end
    dbg_req = 0;
    for (int k = 0; k < 3; k++) begin eval(); chk("lit_wd_noack", 32'(dbg_ack), 32'h0); adv(); end
    dbg_req = 1;
    for (int k = 0; k < 5; k++) begin
      eval();
      if (k == 4) chk("lit_wd_restart", rom_addr, 32'h30);
      else        chk("lit_wd_fetch", 32'(if_stallreq), 32'h0);
      adv();
    end
    dbg_req = 0;
    eval(); adv();
`else
    // Without the debug port, a constant dbg_req is ignored.
    dbg_req = 1; dbg_addr = 32'h30; if_req = 1;
    for (int k = 0; k < 8; k++) begin
      if_addr = 32'h300 + 32'(4 * k);
      eval();
      chk("lit_nodbg_ack",   32'(dbg_ack), 32'h0);
      chk("lit_nodbg_stall", 32'(if_stallreq), 32'h0);
      chk("lit_nodbg_addr",  rom_addr, 32'h300 + 32'(4 * k));
      adv();
    end
    dbg_req = 0;
`endif

    // Reset in the cycle after a fetch grant discards the read.
    if_req = 1; if_addr = 32'h40;
    eval(); adv();
    rst = 1;
    eval();
    chk("lit_rmid_valid", 32'(if_valid), 32'h0);
    chk("lit_rmid_ce",    32'(rom_ce), 32'h0);
    adv();
    rst = 0; if_req = 0;
    eval();
    chk("lit_rmid_inst", if_inst, 32'h0);
    adv();

    // Random traffic. The debug requester drops its request in the ack cycle
    // and sometimes withdraws early.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = $urandom & 32'h0000_FFFC;
      if (dbg_req) begin
        if (m_last_dbg || $urandom_range(0, 19) == 0) dbg_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        dbg_req  = 1;
        dbg_addr = $urandom & 32'h0000_FFFC;
      end
      eval();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
